fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage with a decoupling fetch queue. It owns the fetch PC and issues one instruction-memory request at a time under a hold-until-response handshake. Returned instructions are buffered with their PC in a FIFO of `FQ_DEPTH` entries for the decode stage. Control-flow redirects (branch/JAL targets, or JALR targets with bit 0 cleared) flush the queue and discard any in-flight response.

## Interface
- `XLEN`, 32, PC/address width (≥ 32).
- `RESET_PC`, 32'h0000_0060, fetch PC after reset.
- `FQ_DEPTH`, 4, fetch-queue entries; power of two, ≥ 2.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_read_o` out 1: request valid; held high until `imem_resp_i`.
- `imem_address_o` out XLEN: fetch address; stable while `imem_read_o` is high.
- `imem_rdata_i` in 32: instruction word; valid when `imem_resp_i` is high.
- `imem_resp_i` in 1: single-cycle response strobe for the outstanding request.
- `redirect_i` in 1: flush and restart fetch at the target.
- `redirect_target_i` in XLEN: new fetch PC.
- `redirect_clr_lsb_i` in 1: when high, target bit 0 is forced to 0 (JALR).
- `deq_ready_i` in 1: decode accepts the head entry.
- `deq_valid_o` out 1: head entry valid.
- `deq_instr_o` out 32: head instruction.
- `deq_pc_o` out XLEN: head PC.
- `count_o` out $clog2(FQ_DEPTH+1): number of valid queue entries.

## Operation
- State: fetch PC `fpc`, FSM {IDLE, REQ, DRAIN}, FIFO with read/write pointers and `count`.
- `imem_read_o` = (state == REQ) or (state == DRAIN). `imem_address_o` = address latched at issue.
- Slot reservation: a request may be in REQ only if `count_next + 1 ≤ FQ_DEPTH`. A response therefore never meets a full queue.
- IDLE → REQ when `count_next < FQ_DEPTH` and no redirect; the address latches `fpc`.
- REQ with `imem_resp_i` and no redirect:
  - push {`fpc`, `imem_rdata_i`}; `fpc += 4` (mod 2^XLEN).
  - stay in REQ with the new address if space remains; otherwise go to IDLE.
- REQ with `redirect_i` and no resp: go to DRAIN; the old request completes and its data is dropped.
- REQ with `redirect_i` and `imem_resp_i` in the same cycle: drop the data, go to IDLE.
- DRAIN with `imem_resp_i`: drop the data, go to IDLE. A redirect in DRAIN only updates `fpc`.
- Any redirect:
  - `fpc <= redirect_target_i & ~{XLEN-1'b0, redirect_clr_lsb_i}`.
  - queue emptied; `count_next = 0`.
  - `deq_valid_o` forced to 0 combinationally in that cycle, and no pop occurs.
- Dequeue: pop when `deq_valid_o && deq_ready_i`. Push and pop in the same cycle leave `count` unchanged. Pointers wrap modulo `FQ_DEPTH`.
- `deq_valid_o = (count != 0) && !redirect_i`. Head outputs are undefined when invalid.

## Timing
- Reset values (asserted asynchronously):
  - `fpc = RESET_PC`; state IDLE; `count_o = 0`.
  - `imem_read_o = 0`; `deq_valid_o = 0`; pointers 0.
- First `imem_read_o` is seen in the first cycle after the first clock edge with `rst` low.
- Response in cycle N gives `deq_valid_o` in cycle N+1 (no bypass).
- With zero-wait memory and an empty queue:
  - next request issued in cycle N+1.
  - sustained throughput is 1 instruction per resp cycle, up to `FQ_DEPTH` without dequeue.
- The memory address never changes while `imem_read_o` is high and no resp has been returned.
- `rst` mid-request abandons the transaction; the bench's memory model must also reset.

## Test plan
- Reset, `RESET_PC` = 0x60, one-cycle memory, `deq_ready_i` = 0:
  - required: requests at 0x60, 0x64, 0x68, 0x6C; then `imem_read_o` = 0 and `count_o` = 4.
  - after that, deq_ready = 1 for one cycle pops PC 0x60 and starts a fetch at 0x70 within 1 cycle.
- Streaming with `deq_ready_i` = 1 and 3-cycle memory latency: decode sees PCs 0x60, 0x64, … in order with correct data, and `count_o` never exceeds 1.
- Redirect in IDLE with target 0x1235 and `clr_lsb` = 1: the next request address is 0x1234 and the queue is empty.
- Redirect to 0x200 while a request to 0x70 is outstanding:
  - the 0x70 response is dropped.
  - the next address is 0x200, and the first dequeued PC is 0x200.
- Redirect in the same cycle as a resp and a deq handshake: data dropped, no pop, `deq_valid_o` = 0 that cycle, and fetch restarts at the target.
- `rst` asserted mid-request with the queue holding 2 entries: the outputs drop to reset values immediately, not at the edge, and the first request afterwards is 0x60.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time, buffers {pc, instr} for decode.
// Latency: a response in cycle N is visible at the dequeue port in cycle N+1; back-to-back requests with zero-wait memory.
// Backpressure: a request is only issued once a queue slot is reserved for it, so a full queue parks the fetcher in IDLE.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_read_o,
  output logic [XLEN-1:0]               imem_address_o,
  input  logic [31:0]                   imem_rdata_i,
  input  logic                          imem_resp_i,
  input  logic                          redirect_i,
  input  logic [XLEN-1:0]               redirect_target_i,
  input  logic                          redirect_clr_lsb_i,
  input  logic                          deq_ready_i,
  output logic                          deq_valid_o,
  output logic [31:0]                   deq_instr_o,
  output logic [XLEN-1:0]               deq_pc_o,
  output logic [$clog2(FQ_DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  // IDLE: nothing outstanding; REQ: live request; DRAIN: request outstanding whose data is already stale.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem [FQ_DEPTH];
  logic [XLEN-1:0] pc_mem    [FQ_DEPTH];

  logic            push;
  logic            pop;
  logic            has_space;
  logic [XLEN-1:0] fpc_plus4;
  logic [XLEN-1:0] redirect_pc;

  assign imem_read_o    = (state_q == REQ) || (state_q == DRAIN);
  assign imem_address_o = addr_q;
  assign deq_instr_o    = instr_mem[rd_ptr_q];
  assign deq_pc_o       = pc_mem[rd_ptr_q];
  assign count_o        = count_q;
  assign fpc_plus4      = fpc_q + XLEN'(4);
  assign redirect_pc    = redirect_target_i & ~{{(XLEN-1){1'b0}}, redirect_clr_lsb_i};

  // Queue bookkeeping: a redirect empties the queue and suppresses both the head valid and any pop/push.
  always_comb begin
    deq_valid_o = (count_q != '0) && !redirect_i;
    pop         = deq_valid_o && deq_ready_i;
    push        = (state_q == REQ) && imem_resp_i && !redirect_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    has_space = (count_d < DEPTH_C);
  end

  // Fetch sequencing: issue only into a reserved slot, chain the next request on each live response.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (!redirect_i && has_space) begin
          state_d = REQ;
          addr_d  = fpc_q;
        end
      end
      REQ: begin
        if (redirect_i) begin
          state_d = imem_resp_i ? IDLE : DRAIN;
        end else if (imem_resp_i) begin
          fpc_d = fpc_plus4;
          if (has_space) begin
            state_d = REQ;
            addr_d  = fpc_plus4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (imem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fpc_d = redirect_pc;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      addr_q   <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage: contents are only meaningful under count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= fpc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_resp_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = 32'h0;
  logic        redirect_clr_lsb_i = 1'b0;
  logic        deq_ready_i = 1'b0;
  logic        deq_valid_o;
  logic [31:0] deq_instr_o;
  logic [31:0] deq_pc_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0060), .FQ_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imem_read_o(imem_read_o), .imem_address_o(imem_address_o),
    .imem_rdata_i(imem_rdata_i), .imem_resp_i(imem_resp_i),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .redirect_clr_lsb_i(redirect_clr_lsb_i), .deq_ready_i(deq_ready_i),
    .deq_valid_o(deq_valid_o), .deq_instr_o(deq_instr_o), .deq_pc_o(deq_pc_o),
    .count_o(count_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: expected queue contents plus the single outstanding request.
  logic [31:0] m_pc_q[$];
  logic [31:0] m_in_q[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_fpc;

  int          mem_lat = 1;
  int          mem_wait = 0;
  bit          fresh = 1'b1;
  logic [31:0] issued[$];
  logic [31:0] deq_log[$];
  bit          last_deq_valid;
  int          max_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_pc_q.delete();
    m_in_q.delete();
    m_out  = 1'b0;
    m_drop = 1'b0;
    m_addr = 32'h0;
    m_fpc  = 32'h0000_0060;
  endtask

  task automatic mem_drive();
    if (imem_read_o && (mem_wait + 1 >= mem_lat)) begin
      imem_resp_i  = 1'b1;
      imem_rdata_i = $urandom;
    end else begin
      imem_resp_i  = 1'b0;
    end
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = (m_pc_q.size() != 0) && !redirect_i;
    chk("read", 32'(imem_read_o), 32'(m_out));
    if (m_out) chk("addr", imem_address_o, m_addr);
    chk("deq_valid", 32'(deq_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      chk("deq_pc", deq_pc_o, m_pc_q[0]);
      chk("deq_instr", deq_instr_o, m_in_q[0]);
    end
    chk("count", 32'(count_o), 32'(m_pc_q.size()));
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_update();
    bit          live;
    logic [31:0] nfpc;
    if (redirect_i) begin
      m_pc_q.delete();
      m_in_q.delete();
    end else if (m_pc_q.size() != 0 && deq_ready_i) begin
      void'(m_pc_q.pop_front());
      void'(m_in_q.pop_front());
    end
    nfpc = m_fpc;
    if (m_out && imem_resp_i) begin
      live   = !m_drop;
      m_out  = 1'b0;
      m_drop = 1'b0;
      if (live && !redirect_i) begin
        m_pc_q.push_back(m_addr);
        m_in_q.push_back(imem_rdata_i);
        nfpc = m_fpc + 32'd4;
        if (m_pc_q.size() < D) begin
          m_out  = 1'b1;
          m_addr = nfpc;
        end
      end
    end else if (m_out) begin
      if (redirect_i) m_drop = 1'b1;
    end else if (!redirect_i && m_pc_q.size() < D) begin
      m_out  = 1'b1;
      m_addr = m_fpc;
    end
    if (redirect_i) nfpc = redirect_target_i & ~{31'b0, redirect_clr_lsb_i};
    m_fpc = nfpc;
  endtask

  task automatic step();
    mem_drive();
    #1;
    compare();
    last_deq_valid = deq_valid_o;
    if (int'(count_o) > max_count) max_count = int'(count_o);
    if (imem_read_o && fresh) issued.push_back(imem_address_o);
    fresh = !imem_read_o || imem_resp_i;
    if (deq_valid_o && deq_ready_i) deq_log.push_back(deq_pc_o);
    model_update();
    if (imem_read_o) mem_wait = imem_resp_i ? 0 : mem_wait + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_resp_i = 1'b0;
    redirect_i  = 1'b0;
    deq_ready_i = 1'b0;
    #1;
    chk("rst_read", 32'(imem_read_o), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_wait  = 0;
    fresh     = 1'b1;
    issued.delete();
    deq_log.delete();
    max_count = 0;
  endtask

  initial begin
    bit ok;
    int n0;
    #2;
    do_reset();

    // Fill with one-cycle memory and no dequeue.
    mem_lat = 1;
    repeat (10) step();
    chk("fill_n_req", 32'(issued.size()), 32'd4);
    chk("fill_req0", q_at(issued, 0), 32'h60);
    chk("fill_req1", q_at(issued, 1), 32'h64);
    chk("fill_req2", q_at(issued, 2), 32'h68);
    chk("fill_req3", q_at(issued, 3), 32'h6C);
    chk("fill_idle", 32'(imem_read_o), 32'd0);
    chk("fill_count", 32'(count_o), 32'd4);
    chk("fill_head", deq_pc_o, 32'h60);
    mem_lat = 3;
    deq_ready_i = 1'b1;
    step();
    deq_ready_i = 1'b0;
    chk("pop_pc", q_at(deq_log, 0), 32'h60);
    chk("refetch_read", 32'(imem_read_o), 32'd1);
    chk("refetch_addr", imem_address_o, 32'h70);
    chk("refetch_count", 32'(count_o), 32'd3);

    // Redirect while 0x70 is outstanding.
    redirect_i = 1'b1; redirect_target_i = 32'h200; redirect_clr_lsb_i = 1'b0;
    step();
    redirect_i = 1'b0;
    chk("rdr_flush_count", 32'(count_o), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (issued.size() >= 6) begin ok = 1'b1; break; end
      step();
    end
    chk("rdr_restart_reached", 32'(ok), 32'd1);
    chk("rdr_old_req", q_at(issued, 4), 32'h70);
    chk("rdr_new_req", q_at(issued, 5), 32'h200);
    deq_ready_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (deq_log.size() >= 2) begin ok = 1'b1; break; end
      step();
    end
    chk("rdr_deq_reached", 32'(ok), 32'd1);
    chk("rdr_first_deq", q_at(deq_log, 1), 32'h200);

    // Redirect while idle on a full queue, with bit 0 cleared.
    deq_ready_i = 1'b0;
    mem_lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!imem_read_o && count_o == 3'd4) begin ok = 1'b1; break; end
      step();
    end
    chk("idle_full_reached", 32'(ok), 32'd1);
    redirect_i = 1'b1; redirect_target_i = 32'h1235; redirect_clr_lsb_i = 1'b1;
    step();
    redirect_i = 1'b0; redirect_clr_lsb_i = 1'b0;
    chk("idle_rdr_count", 32'(count_o), 32'd0);
    chk("idle_rdr_read", 32'(imem_read_o), 32'd0);
    step();
    chk("idle_rdr_read2", 32'(imem_read_o), 32'd1);
    chk("idle_rdr_addr", imem_address_o, 32'h1234);

    // Redirect coinciding with a response and a dequeue handshake.
    mem_lat = 2;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (count_o >= 3'd1 && imem_read_o && (mem_wait + 1 >= mem_lat)) begin ok = 1'b1; break; end
      step();
    end
    chk("coinc_reached", 32'(ok), 32'd1);
    redirect_i = 1'b1; redirect_target_i = 32'h300; deq_ready_i = 1'b1;
    n0 = deq_log.size();
    step();
    redirect_i = 1'b0; deq_ready_i = 1'b0;
    chk("coinc_valid", 32'(last_deq_valid), 32'd0);
    chk("coinc_no_pop", 32'(deq_log.size()), 32'(n0));
    chk("coinc_count", 32'(count_o), 32'd0);
    n0 = issued.size();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (issued.size() > n0 && count_o >= 3'd1) begin ok = 1'b1; break; end
      step();
    end
    chk("coinc_restart_reached", 32'(ok), 32'd1);
    chk("coinc_restart_addr", q_at(issued, n0), 32'h300);
    chk("coinc_head_pc", deq_pc_o, 32'h300);

    // Streaming with 3-cycle memory and decode always ready.
    do_reset();
    mem_lat = 3;
    deq_ready_i = 1'b1;
    repeat (40) step();
    chk("stream_pc0", q_at(deq_log, 0), 32'h60);
    chk("stream_pc1", q_at(deq_log, 1), 32'h64);
    chk("stream_pc2", q_at(deq_log, 2), 32'h68);
    chk("stream_max_count_le1", 32'(max_count <= 1), 32'd1);

    // Reset mid-request with two entries queued.
    deq_ready_i = 1'b0;
    mem_lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (count_o == 3'd2 && imem_read_o) begin ok = 1'b1; break; end
      step();
    end
    chk("midrst_reached", 32'(ok), 32'd1);
    do_reset();
    repeat (3) step();
    chk("midrst_first_req", q_at(issued, 0), 32'h60);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      deq_ready_i        = ($urandom_range(0, 3) != 0);
      redirect_i         = ($urandom_range(0, 15) == 0);
      redirect_clr_lsb_i = $urandom_range(0, 1) != 0;
      redirect_target_i  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
      if (mem_wait == 0) mem_lat = $urandom_range(1, 4);
      step();
    end
    redirect_i  = 1'b0;
    deq_ready_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
